control_pipeline: RTL
=====================

CONTROL_PIPELINE -- requirements
Module: control_pipeline

Interface
REQ-001 Parameter LEN_EXEC_BUS, default 11, execute control bus width; bit layout {JumpLink, JALOnly, RegDst, ALUSrc1, ALUSrc2, Jump, JumpReg, ALUCode[3:0]}.
REQ-002 Parameter LEN_MEM_BUS, default 9, memory control bus width; bit layout {BNE, SB, SH, LB, LH, Unsigned, Branch, MemRead, MemWrite}.
REQ-003 Parameter LEN_WB_BUS, default 2, write-back control bus width; bit layout {RegWrite, MemtoReg}.
REQ-004 Parameter REG_ADDR_W, default 5, register address width.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 i_enable  in  1  global advance enable (debug-unit stepping); low freezes all state.
REQ-008 i_valid  in  1  i_instr holds a valid ID-stage instruction.
REQ-009 i_instr  in  32  ID-stage instruction word.
REQ-010 i_flush  in  1  control-hazard kill (taken branch/jump resolved downstream).
REQ-011 o_stall  out  1  load-use hazard; upstream holds PC and IF/ID.
REQ-012 o_ex_bus / o_mem_bus / o_wb_bus  out  LEN_EXEC_BUS / LEN_MEM_BUS / LEN_WB_BUS  control of the EX, MEM and WB stages respectively.
REQ-013 o_ex_valid, o_mem_valid, o_wb_valid  out  1 each  stage-valid flags.
REQ-014 o_wb_reg  out  REG_ADDR_W  destination register of the WB-stage instruction.
REQ-015 o_illegal  out  1  one-cycle pulse when an unsupported opcode/funct enters EX.

Function
REQ-016 Decode SHALL be combinational from i_instr[31:26] (opcode) and i_instr[5:0] (funct), with these encodings: R-type ex[10:4]=0010000, wb=10; shift-by-shamt (funct 000000/000010/000011) ex[10:4]=0011000; JR ex[10:4]=0000001, wb=00; JALR ex[10:4]=1010001, wb=10; loads ex[10:4]=0000100, MemRead=1, wb=11, with LB/LH/Unsigned bits per width and sign; stores MemWrite=1, wb=00, with SB/SH bits; immediate ALU ops ex[10:4]=0000100, wb=10; BEQ Branch=1; BNE Branch=1 and BNE=1; J ex[10:4]=0000010; JAL ex[10:4]=1100010, wb=10.
REQ-017 Unsupported encodings SHALL decode to all-zero buses with the illegal flag set.
REQ-018 Destination register = 31 for JAL; rd (bits 15:11) when RegDst=1; rt (bits 20:16) otherwise.
REQ-019 Three registered stages SHALL be held: ID/EX, EX/MEM and MEM/WB; each carries its buses, valid flag, destination register and illegal flag; latency from ID to each output is 1, 2 and 3 cycles respectively.
REQ-020 Load-use hazard: o_stall=1 combinationally when the EX stage is valid, its MemRead=1, its destination is nonzero, i_valid=1, and the destination equals rs, or equals rt for any instruction that reads rt (R-type, stores, BEQ, BNE).
REQ-021 On stall with i_enable=1: ID/EX SHALL load a bubble (all buses 0, valid 0) while EX/MEM and MEM/WB advance normally.
REQ-022 i_flush=1 SHALL load a bubble into ID/EX and force o_stall=0; flush has priority over stall.
REQ-023 i_enable=0: all stage registers hold their values, o_stall=0, o_illegal=0.
REQ-024 An invalid ID instruction (i_valid=0) SHALL enter ID/EX as a bubble.
REQ-025 o_illegal SHALL be high exactly one cycle, on the cycle the illegal instruction becomes valid in EX.

Reset
REQ-026 rst_n low SHALL asynchronously clear every stage register: all buses 0, all valid flags 0, o_wb_reg 0, o_illegal 0, o_stall 0.
REQ-027 Reset asserted mid-stall or mid-flush SHALL abandon that operation; the first edge after release SHALL capture the ID inputs normally.

Structure
REQ-028 Bus widths, bit-index constants for named bus fields, and opcode/funct constants SHALL reside in a shared package, control_pkg.
REQ-029 ALU code generation SHALL be a single sub-module, alu_control (funct plus a 3-bit aluop in, 4-bit code out).

Verification
REQ-030 LW $2 at ID, reset released -> o_ex_bus[10:4]=0000100 after 1 cycle, o_mem_bus=000000010 after 2 cycles, o_wb_bus=11 with o_wb_reg=2 after 3 cycles.
REQ-031 LW $2 followed by ADD $3,$2,$4 -> o_stall=1 for exactly one cycle; the next EX stage is a bubble; the ADD reaches EX one cycle later.
REQ-032 LW $0 followed by a use of $0 -> o_stall stays 0.
REQ-033 Stall and i_flush asserted in the same cycle -> o_stall=0, ID/EX bubble, and no duplicate ADD issued.
REQ-034 JAL with i_enable toggled 1,0,0,1 -> outputs frozen for two cycles; o_wb_reg=31 and o_wb_bus=10 appear after 3 enabled cycles.
REQ-035 Opcode 111111 -> o_illegal one-cycle pulse, all buses 0; rst_n pulsed mid-pipeline -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/control_pkg.sv
// Shared constants for the control pipeline: bus widths, named bus bit
// positions, MIPS opcode/funct encodings, ALU operation classes and ALU codes.
package control_pkg;

  localparam int EX_BUS_W  = 11;
  localparam int MEM_BUS_W = 9;
  localparam int WB_BUS_W  = 2;
  localparam int REG_W     = 5;

  // execute bus: {JumpLink, JALOnly, RegDst, ALUSrc1, ALUSrc2, Jump, JumpReg, ALUCode[3:0]}
  localparam int EX_JUMPLINK = 10;
  localparam int EX_JALONLY  = 9;
  localparam int EX_REGDST   = 8;
  localparam int EX_ALUSRC1  = 7;
  localparam int EX_ALUSRC2  = 6;
  localparam int EX_JUMP     = 5;
  localparam int EX_JUMPREG  = 4;
  localparam int ALU_CODE_W  = 4;

  // memory bus: {BNE, SB, SH, LB, LH, Unsigned, Branch, MemRead, MemWrite}
  localparam int MEM_BNE      = 8;
  localparam int MEM_SB       = 7;
  localparam int MEM_SH       = 6;
  localparam int MEM_LB       = 5;
  localparam int MEM_LH       = 4;
  localparam int MEM_UNSIGNED = 3;
  localparam int MEM_BRANCH   = 2;
  localparam int MEM_READ     = 1;
  localparam int MEM_WRITE    = 0;

  // write-back bus: {RegWrite, MemtoReg}
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [2:0] {
    ALUOP_ADD   = 3'd0,
    ALUOP_SUB   = 3'd1,
    ALUOP_RTYPE = 3'd2,
    ALUOP_AND   = 3'd3,
    ALUOP_OR    = 3'd4,
    ALUOP_XOR   = 3'd5,
    ALUOP_LUI   = 3'd6
  } aluop_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_ADDU = 4'd12;
  localparam logic [3:0] ALU_SUBU = 4'd13;

endpackage

// File: rtl/alu_control.sv
// ALU code generation from the decoder's operation class and the R-type funct.
// Variable shifts share codes with the shamt shifts; ALUSrc1 picks the amount.
module alu_control
  import control_pkg::*;
(
  input  logic [5:0]            funct,
  input  aluop_e                aluop,
  output logic [ALU_CODE_W-1:0] alu_code
);

  // map operation class (and funct for R-type) to an ALU code
  always_comb begin
    alu_code = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_code = ALU_ADD;
      ALUOP_SUB: alu_code = ALU_SUB;
      ALUOP_AND: alu_code = ALU_AND;
      ALUOP_OR:  alu_code = ALU_OR;
      ALUOP_XOR: alu_code = ALU_XOR;
      ALUOP_LUI: alu_code = ALU_LUI;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD:          alu_code = ALU_ADD;
          FN_ADDU:         alu_code = ALU_ADDU;
          FN_SUB:          alu_code = ALU_SUB;
          FN_SUBU:         alu_code = ALU_SUBU;
          FN_AND:          alu_code = ALU_AND;
          FN_OR:           alu_code = ALU_OR;
          FN_XOR:          alu_code = ALU_XOR;
          FN_NOR:          alu_code = ALU_NOR;
          FN_SLT:          alu_code = ALU_SLT;
          FN_SLTU:         alu_code = ALU_SLTU;
          FN_SLL, FN_SLLV: alu_code = ALU_SLL;
          FN_SRL, FN_SRLV: alu_code = ALU_SRL;
          FN_SRA, FN_SRAV: alu_code = ALU_SRA;
          default:         alu_code = ALU_ADD;
        endcase
      end
      default: alu_code = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_pipeline.sv
// ID-stage control decode feeding ID/EX, EX/MEM and MEM/WB control registers,
// with load-use stall detection, flush-to-bubble and global enable freeze.
module control_pipeline
  import control_pkg::*;
#(
  parameter int LEN_EXEC_BUS = EX_BUS_W,
  parameter int LEN_MEM_BUS  = MEM_BUS_W,
  parameter int LEN_WB_BUS   = WB_BUS_W,
  parameter int REG_ADDR_W   = REG_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_enable,
  input  logic                    i_valid,
  input  logic [31:0]             i_instr,
  input  logic                    i_flush,
  output logic                    o_stall,
  output logic [LEN_EXEC_BUS-1:0] o_ex_bus,
  output logic [LEN_MEM_BUS-1:0]  o_mem_bus,
  output logic [LEN_WB_BUS-1:0]   o_wb_bus,
  output logic                    o_ex_valid,
  output logic                    o_mem_valid,
  output logic                    o_wb_valid,
  output logic [REG_ADDR_W-1:0]   o_wb_reg,
  output logic                    o_illegal
);

  logic [5:0] opcode, funct;
  logic [REG_ADDR_W-1:0] rs, rt, rd;
  assign opcode = i_instr[31:26];
  assign funct  = i_instr[5:0];
  assign rs     = REG_ADDR_W'(i_instr[25:21]);
  assign rt     = REG_ADDR_W'(i_instr[20:16]);
  assign rd     = REG_ADDR_W'(i_instr[15:11]);

  logic [LEN_EXEC_BUS-1:0] dec_ex_ctl, dec_ex;
  logic [LEN_MEM_BUS-1:0]  dec_mem;
  logic [LEN_WB_BUS-1:0]   dec_wb;
  logic [REG_ADDR_W-1:0]   dec_dst;
  logic                    dec_ill, reads_rt;
  aluop_e                  aluop;
  logic [5:0]              alu_funct;
  logic [ALU_CODE_W-1:0]   alu_code;

  // control decode of the ID-stage instruction
  always_comb begin
    dec_ex_ctl = '0;
    dec_mem    = '0;
    dec_wb     = '0;
    dec_ill    = 1'b0;
    reads_rt   = 1'b0;
    aluop      = ALUOP_ADD;
    alu_funct  = funct;
    case (opcode)
      OP_RTYPE: begin
        reads_rt = 1'b1;
        aluop    = ALUOP_RTYPE;
        case (funct)
          FN_SLL, FN_SRL, FN_SRA: begin
            dec_ex_ctl[EX_REGDST]  = 1'b1;
            dec_ex_ctl[EX_ALUSRC1] = 1'b1;
            dec_wb[WB_REGWRITE]    = 1'b1;
          end
          FN_SLLV, FN_SRLV, FN_SRAV, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            dec_ex_ctl[EX_REGDST] = 1'b1;
            dec_wb[WB_REGWRITE]   = 1'b1;
          end
          FN_JR: dec_ex_ctl[EX_JUMPREG] = 1'b1;
          FN_JALR: begin
            dec_ex_ctl[EX_JUMPLINK] = 1'b1;
            dec_ex_ctl[EX_REGDST]   = 1'b1;
            dec_ex_ctl[EX_JUMPREG]  = 1'b1;
            dec_wb[WB_REGWRITE]     = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        dec_ex_ctl[EX_ALUSRC2] = 1'b1;
        dec_mem[MEM_READ]      = 1'b1;
        dec_mem[MEM_LB]        = (opcode == OP_LB) || (opcode == OP_LBU);
        dec_mem[MEM_LH]        = (opcode == OP_LH) || (opcode == OP_LHU);
        dec_mem[MEM_UNSIGNED]  = (opcode == OP_LBU) || (opcode == OP_LHU);
        dec_wb[WB_REGWRITE]    = 1'b1;
        dec_wb[WB_MEMTOREG]    = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: begin
        reads_rt               = 1'b1;
        dec_ex_ctl[EX_ALUSRC2] = 1'b1;
        dec_mem[MEM_WRITE]     = 1'b1;
        dec_mem[MEM_SB]        = (opcode == OP_SB);
        dec_mem[MEM_SH]        = (opcode == OP_SH);
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SLTI, OP_SLTIU: begin
        dec_ex_ctl[EX_ALUSRC2] = 1'b1;
        dec_wb[WB_REGWRITE]    = 1'b1;
        case (opcode)
          OP_ANDI:  aluop = ALUOP_AND;
          OP_ORI:   aluop = ALUOP_OR;
          OP_XORI:  aluop = ALUOP_XOR;
          OP_LUI:   aluop = ALUOP_LUI;
          // immediate compares reuse the R-type SLT/SLTU code path
          OP_SLTI:  begin aluop = ALUOP_RTYPE; alu_funct = FN_SLT;  end
          OP_SLTIU: begin aluop = ALUOP_RTYPE; alu_funct = FN_SLTU; end
          default:  aluop = ALUOP_ADD;
        endcase
      end
      OP_BEQ, OP_BNE: begin
        reads_rt            = 1'b1;
        aluop               = ALUOP_SUB;
        dec_mem[MEM_BRANCH] = 1'b1;
        dec_mem[MEM_BNE]    = (opcode == OP_BNE);
      end
      OP_J: dec_ex_ctl[EX_JUMP] = 1'b1;
      OP_JAL: begin
        dec_ex_ctl[EX_JUMPLINK] = 1'b1;
        dec_ex_ctl[EX_JALONLY]  = 1'b1;
        dec_ex_ctl[EX_JUMP]     = 1'b1;
        dec_wb[WB_REGWRITE]     = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  alu_control u_alu_control (
    .funct    (alu_funct),
    .aluop    (aluop),
    .alu_code (alu_code)
  );

  assign dec_ex  = dec_ill ? '0 : (dec_ex_ctl | LEN_EXEC_BUS'(alu_code));
  assign dec_dst = dec_ill                      ? '0 :
                   (opcode == OP_JAL)           ? REG_ADDR_W'(31) :
                   dec_ex_ctl[EX_REGDST]        ? rd : rt;

  logic [LEN_EXEC_BUS-1:0] ex_bus_q;
  logic [LEN_MEM_BUS-1:0]  ex_mem_q, mem_mem_q;
  logic [LEN_WB_BUS-1:0]   ex_wb_q, mem_wb_q, wb_wb_q;
  logic                    ex_valid_q, mem_valid_q, wb_valid_q;
  logic [REG_ADDR_W-1:0]   ex_dst_q, mem_dst_q, wb_dst_q;
  logic                    ex_ill_q, mem_ill_q, wb_ill_q;
  logic                    ill_pulse_q;
  logic                    load_use, take_id;

  assign load_use = ex_valid_q && ex_mem_q[MEM_READ] && (ex_dst_q != '0) && i_valid &&
                    ((ex_dst_q == rs) || (reads_rt && (ex_dst_q == rt)));
  assign take_id  = i_valid && !i_flush && !load_use;
  assign o_stall  = load_use && i_enable && !i_flush;

  // stage registers: ID/EX takes the decode or a bubble, later stages shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_bus_q    <= '0;
      ex_mem_q    <= '0;
      ex_wb_q     <= '0;
      ex_valid_q  <= 1'b0;
      ex_dst_q    <= '0;
      ex_ill_q    <= 1'b0;
      mem_mem_q   <= '0;
      mem_wb_q    <= '0;
      mem_valid_q <= 1'b0;
      mem_dst_q   <= '0;
      mem_ill_q   <= 1'b0;
      wb_wb_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_dst_q    <= '0;
      wb_ill_q    <= 1'b0;
      ill_pulse_q <= 1'b0;
    end else if (i_enable) begin
      if (take_id) begin
        ex_bus_q   <= dec_ex;
        ex_mem_q   <= dec_mem;
        ex_wb_q    <= dec_wb;
        ex_valid_q <= 1'b1;
        ex_dst_q   <= dec_dst;
        ex_ill_q   <= dec_ill;
      end else begin
        ex_bus_q   <= '0;
        ex_mem_q   <= '0;
        ex_wb_q    <= '0;
        ex_valid_q <= 1'b0;
        ex_dst_q   <= '0;
        ex_ill_q   <= 1'b0;
      end
      mem_mem_q   <= ex_mem_q;
      mem_wb_q    <= ex_wb_q;
      mem_valid_q <= ex_valid_q;
      mem_dst_q   <= ex_dst_q;
      mem_ill_q   <= ex_ill_q;
      wb_wb_q     <= mem_wb_q;
      wb_valid_q  <= mem_valid_q;
      wb_dst_q    <= mem_dst_q;
      wb_ill_q    <= mem_ill_q;
      ill_pulse_q <= take_id && dec_ill;
    end else begin
      // a frozen cycle consumes the pulse so it never reappears on resume
      ill_pulse_q <= 1'b0;
    end
  end

  assign o_ex_bus    = ex_bus_q;
  assign o_mem_bus   = mem_mem_q;
  assign o_wb_bus    = wb_wb_q;
  assign o_ex_valid  = ex_valid_q;
  assign o_mem_valid = mem_valid_q;
  assign o_wb_valid  = wb_valid_q;
  assign o_wb_reg    = wb_dst_q;
  assign o_illegal   = ill_pulse_q && i_enable;

  // shamt is consumed by the EX datapath; the WB illegal flag has no consumer here
  logic unused_bits;
  assign unused_bits = ^{i_instr[10:6], wb_ill_q};

endmodule
